// File: rtl/deco416_pkg.sv
// Shared types and helpers for the deco_416 registered one-hot decoder.
// Optional one-hot checker is enabled with the DECO416_ONEHOT_CHECK_EN macro.
package deco416_pkg;

  localparam int IN_W  = 4;
  localparam int OUT_W = 16;  // always 2**IN_W

  typedef logic [IN_W-1:0]  sel_t;
  typedef logic [OUT_W-1:0] onehot_t;
  typedef logic [IN_W:0]    count_t;  // wide enough to hold OUT_W

  // Binary index to one-hot line; every index value maps to a real line.
  function automatic onehot_t decode(input sel_t sel);
    return onehot_t'(1) << sel;
  endfunction

  // Number of set bits in a decode vector.
  function automatic count_t popcount(input onehot_t v);
    count_t n;
    n = '0;
    for (int i = 0; i < OUT_W; i++) begin
      n = n + count_t'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/deco_416_onehot_check.sv
// Combinational invariant check for the deco_416 output pair:
// a valid decode must have exactly one bit set, an invalid one must be zero.
// Only instantiated when DECO416_ONEHOT_CHECK_EN is defined.
module onehot_check
  import deco416_pkg::*;
(
  input  logic    valid_i,
  input  onehot_t onehot_i,
  output logic    err_next_o
);

  // Flag any output state that breaks the one-hot/zero invariant.
  always_comb begin
    if (valid_i) begin
      err_next_o = (popcount(onehot_i) != count_t'(1));
    end else begin
      err_next_o = (onehot_i != '0);
    end
  end

endmodule

// File: rtl/deco_416.sv
// deco_416: registered 4-to-16 one-hot decoder with enable.
// o/valid come straight from flops, so there is no combinational path from
// x/en to the outputs and the one-hot strobe is glitch-free.
// Define DECO416_ONEHOT_CHECK_EN to add a sticky err output driven by an
// invariant checker on the registered outputs.
module deco_416
  import deco416_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] o,
  output logic             valid
`ifdef DECO416_ONEHOT_CHECK_EN
  ,
  output logic             err
`endif
);

  onehot_t o_q, o_d;
  logic    valid_q, valid_d;

  // Next decode: one line for an enabled sample, all lines cleared otherwise.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch.
    o_d     = '0;
    valid_d = 1'b0;
    if (en) begin
      o_d     = decode(sel_t'(x));
      valid_d = 1'b1;
    end
  end

  // Output registers; reset clears them without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking so all flops update together from pre-edge values.
    if (rst) begin
      o_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      o_q     <= o_d;
      valid_q <= valid_d;
    end
  end

  assign o     = o_q;
  assign valid = valid_q;

`ifdef DECO416_ONEHOT_CHECK_EN
  logic err_next;
  logic err_q;

  // The checker watches the actual output pins, one cycle behind.
  onehot_check u_onehot_check (
    .valid_i    (valid),
    .onehot_i   (o),
    .err_next_o (err_next)
  );

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | err_next;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_deco_416.sv
// Self-checking bench for deco_416: directed literal cases plus randomized
// stream compared every cycle against a behavioural model.
// Define DECO416_ONEHOT_CHECK_EN to also exercise the err output.
module tb_deco_416;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  x;
  logic [15:0] o;
  logic        valid;
`ifdef DECO416_ONEHOT_CHECK_EN
  logic        err;
`endif

  int total;
  int bad;

  // Behavioural model state: what the outputs must show right now.
  logic [15:0] m_o;
  logic        m_v;
  bit          cmp_en;

  deco_416 dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .x     (x),
    .o     (o),
    .valid (valid)
`ifdef DECO416_ONEHOT_CHECK_EN
    ,
    .err   (err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the output is line x of the last enabled sample, else nothing.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_o = 16'h0000;
      m_v = 1'b0;
    end else begin
      m_v = en;
      for (int i = 0; i < 16; i++) begin
        m_o[i] = (en === 1'b1) && (x == i);
      end
    end
  end

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model", {15'd0, valid, o}, {15'd0, m_v, m_o});
    end
  end

  // Apply one sample, step one edge, check the registered result.
  task automatic drive_check(input logic [3:0] xv, input logic ev,
                             input logic [15:0] exp_o, input logic exp_v,
                             input string name);
    x  = xv;
    en = ev;
    @(posedge clk);
    #1;
    check(name, {15'd0, valid, o}, {15'd0, exp_v, exp_o});
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    cmp_en = 1'b0;
    rst    = 1'b0;
    en     = 1'b0;
    x      = 4'd0;
    m_o    = 16'h0000;
    m_v    = 1'b0;

    // Asynchronous reset with no clock edge yet.
    #1;
    x  = 4'b1111;
    en = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check("rst_async", {15'd0, valid, o}, 32'd0);
    cmp_en = 1'b1;
    @(posedge clk);
    #1;
    check("rst_hold", {15'd0, valid, o}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release", {15'd0, valid, o}, {15'd0, 1'b1, 16'h8000});

    // Single-bit walk.
    drive_check(4'b0000, 1'b1, 16'h0001, 1'b1, "walk0");
    drive_check(4'b0001, 1'b1, 16'h0002, 1'b1, "walk1");
    drive_check(4'b0010, 1'b1, 16'h0004, 1'b1, "walk2");
    drive_check(4'b0100, 1'b1, 16'h0010, 1'b1, "walk4");
    drive_check(4'b1000, 1'b1, 16'h0100, 1'b1, "walk8");

    // Multi-bit patterns.
    drive_check(4'b0011, 1'b1, 16'h0008, 1'b1, "pat3");
    drive_check(4'b0110, 1'b1, 16'h0040, 1'b1, "pat6");
    drive_check(4'b1100, 1'b1, 16'h1000, 1'b1, "pat12");
    drive_check(4'b0101, 1'b1, 16'h0020, 1'b1, "pat5");
    drive_check(4'b1010, 1'b1, 16'h0400, 1'b1, "pat10");
    drive_check(4'b0111, 1'b1, 16'h0080, 1'b1, "pat7");
    drive_check(4'b1110, 1'b1, 16'h4000, 1'b1, "pat14");
    drive_check(4'b1001, 1'b1, 16'h0200, 1'b1, "pat9");
    drive_check(4'b1011, 1'b1, 16'h0800, 1'b1, "pat11");
    drive_check(4'b1101, 1'b1, 16'h2000, 1'b1, "pat13");
    drive_check(4'b1111, 1'b1, 16'h8000, 1'b1, "pat15");
    drive_check(4'b1111, 1'b1, 16'h8000, 1'b1, "repeat15");

    // Enable gating: cleared, not held, then re-enabled.
    drive_check(4'b1110, 1'b1, 16'h4000, 1'b1, "gate_on");
    drive_check(4'b1110, 1'b0, 16'h0000, 1'b0, "gate_off");
    drive_check(4'b0011, 1'b1, 16'h0008, 1'b1, "gate_reon");

    // Mid-stream reset between edges discards the in-flight sample.
    drive_check(4'b0101, 1'b1, 16'h0020, 1'b1, "mid_pre");
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst", {15'd0, valid, o}, 32'd0);
    #1;
    rst = 1'b0;
    drive_check(4'b0011, 1'b1, 16'h0008, 1'b1, "mid_post");

    // Randomized stream with occasional mid-cycle reset pulses.
    for (int n = 0; n < 400; n++) begin
      x  = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        #1;
        rst = 1'b1;
        #1;
        rst = 1'b0;
      end
      @(posedge clk);
      #1;
    end

`ifdef DECO416_ONEHOT_CHECK_EN
    // Clean sweep must never raise err.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive_check(4'(i), 1'b1, 16'h0001 << i, 1'b1, "sweep");
      check("err_sweep", {31'd0, err}, 32'd0);
    end
    drive_check(4'd2, 1'b0, 16'h0000, 1'b0, "sweep_off");
    @(posedge clk);
    #1;
    check("err_sweep_end", {31'd0, err}, 32'd0);

    // Corrupt the outputs: err rises on the next edge and sticks.
    cmp_en = 1'b0;
    x  = 4'd1;
    en = 1'b1;
    @(posedge clk);
    #1;
    force dut.o_q = 16'h0003;
    #1;
    check("err_before_edge", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;
    check("err_set", {31'd0, err}, 32'd1);
    release dut.o_q;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("err_sticky", {31'd0, err}, 32'd1);
    end
    rst = 1'b1;
    #1;
    check("err_rst", {31'd0, err}, 32'd0);
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
